// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures instruction words into a one-deep
// instruction register with valid/ready hand-off, branch redirect and halt.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'hF,
  parameter int                    COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  output logic [ADDR_WIDTH-1:0]  instruction_address,
  input  logic [DATA_WIDTH-1:0]  instruction_data,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [DATA_WIDTH-1:0]  ir_data,
  output logic [ADDR_WIDTH-1:0]  ir_pc,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0]  PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [DATA_WIDTH-1:0]  ir_data_q, ir_data_d;
  logic [ADDR_WIDTH-1:0]  ir_pc_q, ir_pc_d;
  logic                   ir_valid_q, ir_valid_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   slot_free_s;
  logic                   is_halt_s;

  assign slot_free_s = ~ir_valid_q | ir_ready;
  assign is_halt_s   = (instruction_data[DATA_WIDTH-1:DATA_WIDTH-4] == HALT_OPCODE);

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      ir_data_q  <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_data_q  <= ir_data_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic: branch beats capture beats hold
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_data_d  = ir_data_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    count_d    = count_q;
    if (branch_valid) begin
      pc_d       = branch_target;
      ir_valid_d = 1'b0;
      state_d    = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (slot_free_s) begin
            ir_data_d  = instruction_data;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            if (count_q != {COUNT_WIDTH{1'b1}}) begin
              count_d = count_q + CNT_ONE;
            end else begin
              count_d = count_q;
            end
            // A halt word is still handed to decode, but the PC stays on it
            if (is_halt_s) begin
              state_d = S_HALT;
            end else begin
              pc_d = pc_q + PC_ONE;
            end
          end else begin
            ir_valid_d = ir_valid_q;
          end
        end
        S_HALT: begin
          if (ir_valid_q && ir_ready) begin
            ir_valid_d = 1'b0;
          end else begin
            ir_valid_d = ir_valid_q;
          end
        end
        default: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  assign instruction_address = pc_q;
  assign ir_data             = ir_data_q;
  assign ir_pc               = ir_pc_q;
  assign ir_valid            = ir_valid_q;
  assign halted              = (state_q == S_HALT);
  assign fetch_count         = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: spec-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        clr_s;
  logic [3:0]  addr_s, addr2_s;
  logic [15:0] data_s, data2_s;
  logic        bv_s;
  logic [3:0]  bt_s;
  logic [15:0] ir_data_s, ir_data2_s;
  logic [3:0]  ir_pc_s, ir_pc2_s;
  logic        ir_valid_s, ir_valid2_s;
  logic        rdy_s;
  logic        halted_s, halted2_s;
  logic [7:0]  cnt_s;
  logic [3:0]  cnt2_s;

  logic [15:0] mem [16];

  int pass_cnt = 0;
  int total_cnt = 0;
  bit model_on = 1'b0;

  // Spec-level model state
  int          m_pc, m_irpc, m_cnt, m_cnt2;
  logic [15:0] m_ir;
  bit          m_valid, m_halt;

  always #5 clk = ~clk;

  assign data_s  = mem[addr_s];
  assign data2_s = {12'h000, addr2_s};

  instruction_fetch_unit dut (
    .clk(clk), .clr(clr_s),
    .instruction_address(addr_s), .instruction_data(data_s),
    .branch_valid(bv_s), .branch_target(bt_s),
    .ir_data(ir_data_s), .ir_pc(ir_pc_s), .ir_valid(ir_valid_s),
    .ir_ready(rdy_s), .halted(halted_s), .fetch_count(cnt_s)
  );

  instruction_fetch_unit #(.COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .clr(clr_s),
    .instruction_address(addr2_s), .instruction_data(data2_s),
    .branch_valid(1'b0), .branch_target(4'h0),
    .ir_data(ir_data2_s), .ir_pc(ir_pc2_s), .ir_valid(ir_valid2_s),
    .ir_ready(1'b1), .halted(halted2_s), .fetch_count(cnt2_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Model: one instruction slot, PC wraps mod 16, counters saturate
  always @(posedge clk) begin
    if (clr_s) begin
      m_pc <= 0; m_ir <= 16'h0000; m_irpc <= 0; m_valid <= 1'b0;
      m_halt <= 1'b0; m_cnt <= 0; m_cnt2 <= 0;
    end else begin
      m_cnt2 <= (m_cnt2 < 15) ? m_cnt2 + 1 : 15;
      if (bv_s) begin
        m_pc <= int'(bt_s); m_valid <= 1'b0; m_halt <= 1'b0;
      end else if (!m_halt && (!m_valid || rdy_s)) begin
        m_ir <= mem[m_pc]; m_irpc <= m_pc; m_valid <= 1'b1;
        m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
        if (mem[m_pc][15:12] == 4'hF) m_halt <= 1'b1;
        else m_pc <= (m_pc + 1) % 16;
      end else if (m_halt && m_valid && rdy_s) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare process: all outputs against the model every cycle
  always @(negedge clk) begin
    if (model_on) begin
      chk("m_addr", 32'(addr_s), 32'(m_pc));
      chk("m_valid", 32'(ir_valid_s), 32'(m_valid));
      chk("m_ir_data", 32'(ir_data_s), 32'(m_ir));
      chk("m_ir_pc", 32'(ir_pc_s), 32'(m_irpc));
      chk("m_halted", 32'(halted_s), 32'(m_halt));
      chk("m_count", 32'(cnt_s), 32'(m_cnt));
      chk("m_sat_count", 32'(cnt2_s), 32'(m_cnt2));
    end
  end

  task automatic step(input logic c, input logic bv, input logic [3:0] bt, input logic r);
    clr_s = c; bv_s = bv; bt_s = bt; rdy_s = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    clr_s = 1'b1; bv_s = 1'b0; bt_s = 4'h0; rdy_s = 1'b0;
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    model_on = 1'b1;
    chk("rst_valid", 32'(ir_valid_s), 32'd0);
    chk("rst_addr", 32'(addr_s), 32'd0);
    chk("rst_count", 32'(cnt_s), 32'd0);
    chk("rst_halted", 32'(halted_s), 32'd0);

    // Streaming with wrap
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      chk("stream_pc", 32'(ir_pc_s), 32'((k - 1) % 16));
      chk("stream_data", 32'(ir_data_s), 32'((k - 1) % 16));
    end
    chk("stream_count", 32'(cnt_s), 32'd20);
    chk("stream_addr", 32'(addr_s), 32'd4);
    chk("sat_count", 32'(cnt2_s), 32'd15);

    // Backpressure at ir_pc=5
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("bp_pc", 32'(ir_pc_s), 32'd5);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 4'h0, 1'b0);
      chk("bp_data", 32'(ir_data_s), 32'h0005);
      chk("bp_addr", 32'(addr_s), 32'd6);
      chk("bp_count", 32'(cnt_s), 32'd22);
    end
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("bp_release_pc", 32'(ir_pc_s), 32'd6);

    // Branch to 12 while ir_pc=3 is valid and ready
    step(1'b0, 1'b1, 4'd3, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk("br_setup_pc", 32'(ir_pc_s), 32'd3);
    step(1'b0, 1'b1, 4'd12, 1'b1);
    chk("br_flush", 32'(ir_valid_s), 32'd0);
    chk("br_addr", 32'(addr_s), 32'd12);
    chk("br_count", 32'(cnt_s), 32'd24);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("br_pc", 32'(ir_pc_s), 32'd12);
    chk("br_data", 32'(ir_data_s), 32'h000c);

    // Halt word at address 4
    mem[4] = 16'hF123;
    step(1'b0, 1'b1, 4'd2, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("halt_pc", 32'(ir_pc_s), 32'd4);
    chk("halt_data", 32'(ir_data_s), 32'hF123);
    chk("halt_flag", 32'(halted_s), 32'd1);
    chk("halt_addr", 32'(addr_s), 32'd4);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk("halt_hold_valid", 32'(ir_valid_s), 32'd1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("halt_drained", 32'(ir_valid_s), 32'd0);
    chk("halt_addr2", 32'(addr_s), 32'd4);
    chk("halt_count", 32'(cnt_s), 32'd28);
    step(1'b0, 1'b1, 4'd0, 1'b1);
    chk("resume_halted", 32'(halted_s), 32'd0);
    chk("resume_addr", 32'(addr_s), 32'd0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("resume_pc", 32'(ir_pc_s), 32'd0);
    chk("resume_valid", 32'(ir_valid_s), 32'd1);

    // Reset together with a branch while IR is valid
    step(1'b1, 1'b1, 4'd9, 1'b0);
    chk("mrst_valid", 32'(ir_valid_s), 32'd0);
    chk("mrst_addr", 32'(addr_s), 32'd0);
    chk("mrst_count", 32'(cnt_s), 32'd0);
    chk("mrst_halted", 32'(halted_s), 32'd0);

    // Mixed ready pattern, model-checked only
    for (int k = 0; k < 24; k++) step(1'b0, 1'b0, 4'h0, (k % 3) != 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the 16-entry x 16-bit instruction memory. It owns the program counter and drives the memory address. It captures the returned instruction word into an instruction register and hands it to the decode stage over a valid/ready handshake. It also supports branch redirect with flush, halt detection and a fetch counter.

Parameters:
ADDR_WIDTH, 4, PC / instruction memory address width (memory depth 2**ADDR_WIDTH)
DATA_WIDTH, 16, instruction word width
RESET_PC, 0, PC value after reset
HALT_OPCODE, 4'hF, value of instruction bits [DATA_WIDTH-1:DATA_WIDTH-4] that marks a halt instruction
COUNT_WIDTH, 8, width of fetch counter

Ports:
clk  input  1  clock; all state updates on rising edge
clr  input  1  reset; synchronous, active-high
instruction_address  output  ADDR_WIDTH  address to instruction memory; equals PC combinationally
instruction_data  input  DATA_WIDTH  word from instruction memory; combinational read of instruction_address in the same cycle
branch_valid  input  1  redirect request from downstream, one-cycle pulse
branch_target  input  ADDR_WIDTH  redirect address, sampled when branch_valid=1
ir_data  output  DATA_WIDTH  registered instruction to decode
ir_pc  output  ADDR_WIDTH  address the ir_data word was fetched from
ir_valid  output  1  ir_data/ir_pc hold an unconsumed instruction
ir_ready  input  1  decode accepts ir_data this cycle when ir_valid=1
halted  output  1  fetch stopped on a halt instruction
fetch_count  output  COUNT_WIDTH  number of instructions captured since reset, saturating

Behaviour:
- Reset (clr=1 at edge), overriding all other inputs: PC=RESET_PC, ir_data=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0, state=RUN.
- Reset mid-operation discards any pending IR contents and any branch_valid in the same cycle.
- Two states: RUN and HALT. halted=1 exactly when state=HALT.
- Slot free condition: ir_valid=0, or (ir_valid=1 and ir_ready=1).
- Priority per cycle (not in reset): branch, then capture, then hold.
- Branch (branch_valid=1, any state):
  - PC<=branch_target, ir_valid<=0 (flush, even if ir_ready=1 that cycle), state<=RUN.
  - No capture and no fetch_count change that cycle.
- Capture (RUN, no branch, slot free):
  - ir_data<=instruction_data, ir_pc<=PC, ir_valid<=1, fetch_count+=1 (holds at all-ones).
  - If instruction_data top nibble == HALT_OPCODE: state<=HALT and PC holds.
  - Otherwise PC<=PC+1, with modulo wrap from 2**ADDR_WIDTH-1 to 0.
- Hold (RUN, ir_valid=1, ir_ready=0): PC, IR and count unchanged.
- HALT, no branch:
  - No captures; PC frozen.
  - If ir_valid=1 and ir_ready=1, ir_valid<=0; otherwise the IR holds.
- Throughput: one instruction per cycle while ir_ready=1 continuously.
- Latency: a word appears on ir_data one cycle after its address is driven.
- ir_data/ir_pc are unchanged whenever ir_valid=0 (no spurious updates).

Test Plan:
- Bench memory mem[i]=i (16'h0000..16'h000f). Release clr, hold ir_ready=1 for 20 cycles -> ir_pc sequence 0,1,..,15,0,1,2,3; ir_data==ir_pc each cycle; PC wraps 15->0; fetch_count=20.
- Backpressure: ir_ready=0 for 3 cycles while ir_valid=1 with ir_pc=5 -> ir_data=16'h0005 stable, instruction_address stays 6, fetch_count unchanged; ir_ready=1 -> next ir_pc=6.
- Branch: branch_valid=1 with branch_target=12 while ir_valid=1 and ir_pc=3 -> next cycle ir_valid=0 and instruction_address=12; following cycle ir_pc=12, ir_data=16'h000c.
- Halt: mem[4]=16'hF123 -> capture at ir_pc=4, halted=1, instruction_address stays 4, no further captures after decode consumes it. Then branch_valid=1 with branch_target=0 -> halted=0, fetching resumes at 0.
- Reset mid-stream: clr=1 in the same cycle as branch_valid=1 with ir_valid=1 -> next cycle ir_valid=0, instruction_address=RESET_PC, fetch_count=0, halted=0.
- Saturation: set COUNT_WIDTH=4 and run 20 captures -> fetch_count sticks at 15.
